// File: rtl/ibex_hpm_counter_bank.sv
// Parametrised performance-monitor counter bank: one ibex_hpm_counter per slot plus
// a shared inhibit register, a CSR read mux and an OR-reduced overflow interrupt.

module ibex_hpm_counter #(
    parameter int unsigned CounterWidth = 64,
    parameter int unsigned NumEvents    = 16,
    parameter bit          Saturate     = 1'b0,
    parameter bit          IsCycle      = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NumEvents-1:0] events_i,
    input  logic                 inhibit_i,
    input  logic                 wr_lo_i,
    input  logic                 wr_hi_i,
    input  logic                 wr_ev_i,
    input  logic [31:0]          wdata_i,
    output logic [63:0]          cnt_o,
    output logic [31:0]          ev_o,
    output logic                 ovf_o,
    output logic                 irq_o
);
    logic [CounterWidth-1:0] cnt_q, cnt_d;
    logic [NumEvents-1:0]    mask_q, mask_d;
    logic                    irq_en_q, irq_en_d, ovf_q, ovf_d;
    logic                    ev_hit, inc, hw_ovf;
    logic [63:0]             cnt_ext;

    assign cnt_ext = 64'(cnt_q);
    assign ev_hit  = IsCycle ? 1'b1 : |(events_i & mask_q);
    assign inc     = !inhibit_i && ev_hit;

    always_comb begin
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        irq_en_d = irq_en_q;
        ovf_d    = ovf_q;
        hw_ovf   = 1'b0;
        // A software write to the count suppresses that cycle's increment and its overflow.
        if (wr_lo_i) begin
            cnt_d = CounterWidth'({cnt_ext[63:32], wdata_i});
        end else if (wr_hi_i) begin
            cnt_d = CounterWidth'({wdata_i, cnt_ext[31:0]});
        end else if (inc) begin
            if (&cnt_q) begin
                hw_ovf = 1'b1;
                cnt_d  = Saturate ? cnt_q : '0;
            end else begin
                cnt_d = cnt_q + CounterWidth'(1);
            end
        end
        if (wr_ev_i) begin
            mask_d   = IsCycle ? '0 : wdata_i[NumEvents-1:0];
            irq_en_d = wdata_i[30];
            ovf_d    = wdata_i[31];
        end
        if (hw_ovf) ovf_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            mask_q   <= '0;
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            irq_en_q <= irq_en_d;
            ovf_q    <= ovf_d;
        end
    end

    assign cnt_o = cnt_ext;
    assign ev_o  = {ovf_q, irq_en_q, 30'(mask_q)};
    assign ovf_o = ovf_q;
    assign irq_o = ovf_q & irq_en_q;
endmodule

module ibex_hpm_counter_bank #(
    parameter int unsigned NumCounters  = 8,
    parameter int unsigned CounterWidth = 64,
    parameter int unsigned NumEvents    = 16,
    parameter bit          Saturate     = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumEvents-1:0]   events_i,
    input  logic                   csr_en_i,
    input  logic                   csr_we_i,
    input  logic [1:0]             csr_sel_i,
    input  logic [4:0]             csr_idx_i,
    input  logic [31:0]            csr_wdata_i,
    output logic [31:0]            csr_rdata_o,
    output logic                   csr_err_o,
    output logic [NumCounters-1:0] ovf_o,
    output logic                   irq_o
);
    localparam logic [1:0] SelLo = 2'd0, SelHi = 2'd1, SelCtrl = 2'd3;

    logic [NumCounters-1:0]        inhibit_q;
    logic [NumCounters-1:0][63:0]  cnt;
    logic [NumCounters-1:0][31:0]  ev;
    logic [NumCounters-1:0]        irq_src;
    logic                          wr_ok;

    assign csr_err_o = csr_en_i && (csr_sel_i != SelCtrl) && (32'(csr_idx_i) >= NumCounters);
    assign wr_ok     = csr_en_i && csr_we_i && !csr_err_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                           inhibit_q <= '0;
        else if (wr_ok && csr_sel_i == SelCtrl) inhibit_q <= csr_wdata_i[NumCounters-1:0];
    end

    for (genvar g = 0; g < NumCounters; g++) begin : gen_cnt
        logic hit;
        assign hit = wr_ok && (csr_idx_i == 5'(g));
        ibex_hpm_counter #(
            .CounterWidth(CounterWidth),
            .NumEvents   (NumEvents),
            .Saturate    (Saturate),
            .IsCycle     (g == 0)
        ) u_cnt (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .events_i (events_i),
            .inhibit_i(inhibit_q[g]),
            .wr_lo_i  (hit && csr_sel_i == SelLo),
            .wr_hi_i  (hit && csr_sel_i == SelHi),
            .wr_ev_i  (hit && csr_sel_i == 2'd2),
            .wdata_i  (csr_wdata_i),
            .cnt_o    (cnt[g]),
            .ev_o     (ev[g]),
            .ovf_o    (ovf_o[g]),
            .irq_o    (irq_src[g])
        );
    end

    always_comb begin
        csr_rdata_o = '0;
        if (csr_en_i && !csr_err_o) begin
            if (csr_sel_i == SelCtrl) begin
                csr_rdata_o = 32'(inhibit_q);
            end else begin
                for (int i = 0; i < NumCounters; i++) begin
                    if (csr_idx_i == 5'(i)) begin
                        case (csr_sel_i)
                            SelLo:   csr_rdata_o = cnt[i][31:0];
                            SelHi:   csr_rdata_o = cnt[i][63:32];
                            default: csr_rdata_o = ev[i];
                        endcase
                    end
                end
            end
        end
    end

    assign irq_o = |irq_src;
endmodule

// File: tb/tb_ibex_hpm_counter_bank.sv
// Directed bench: three banks (64-bit wrap, 8-bit wrap, 8-bit saturate) share stimulus,
// each with its own CSR enable.

module tb_ibex_hpm_counter_bank;
    localparam logic [1:0] LO = 2'd0, HI = 2'd1, EV = 2'd2, CT = 2'd3;

    logic        clk = 1'b0, rst = 1'b1;
    logic [15:0] events = '0;
    logic        en_a = 1'b0, en_b = 1'b0, en_c = 1'b0, we = 1'b0;
    logic [1:0]  sel = '0;
    logic [4:0]  idx = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata_a, rdata_b, rdata_c;
    logic        err_a, err_b, err_c, irq_a, irq_b, irq_c;
    logic [7:0]  ovf_a, ovf_b, ovf_c;
    int          vectors = 0, errs = 0;

    always #50 clk = ~clk;

    ibex_hpm_counter_bank #(.NumCounters(8), .CounterWidth(64), .NumEvents(16), .Saturate(1'b0)) dut_a (
        .clk_i(clk), .rst_i(rst), .events_i(events), .csr_en_i(en_a), .csr_we_i(we),
        .csr_sel_i(sel), .csr_idx_i(idx), .csr_wdata_i(wdata), .csr_rdata_o(rdata_a),
        .csr_err_o(err_a), .ovf_o(ovf_a), .irq_o(irq_a));
    ibex_hpm_counter_bank #(.NumCounters(8), .CounterWidth(8), .NumEvents(16), .Saturate(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst), .events_i(events), .csr_en_i(en_b), .csr_we_i(we),
        .csr_sel_i(sel), .csr_idx_i(idx), .csr_wdata_i(wdata), .csr_rdata_o(rdata_b),
        .csr_err_o(err_b), .ovf_o(ovf_b), .irq_o(irq_b));
    ibex_hpm_counter_bank #(.NumCounters(8), .CounterWidth(8), .NumEvents(16), .Saturate(1'b1)) dut_c (
        .clk_i(clk), .rst_i(rst), .events_i(events), .csr_en_i(en_c), .csr_we_i(we),
        .csr_sel_i(sel), .csr_idx_i(idx), .csr_wdata_i(wdata), .csr_rdata_o(rdata_c),
        .csr_err_o(err_c), .ovf_o(ovf_c), .irq_o(irq_c));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [2:0] d, input logic [1:0] s, input logic [4:0] ix, input logic [31:0] dat);
        {en_c, en_b, en_a} = d; we = 1'b1; sel = s; idx = ix; wdata = dat;
        tick();
        {en_c, en_b, en_a} = '0; we = 1'b0;
    endtask

    task automatic rd(input int d, input logic [1:0] s, input logic [4:0] ix, input logic [31:0] exp,
                      input string tag);
        logic [31:0] r;
        {en_c, en_b, en_a} = 3'(1 << d); we = 1'b0; sel = s; idx = ix;
        #1;
        r = (d == 0) ? rdata_a : (d == 1) ? rdata_b : rdata_c;
        chk(tag, 64'(r), 64'(exp));
        {en_c, en_b, en_a} = '0;
    endtask

    task automatic rd_err(input logic [1:0] s, input logic [4:0] ix, input logic exp_err,
                          input logic [31:0] exp, input string tag);
        en_a = 1'b1; we = 1'b0; sel = s; idx = ix;
        #1;
        chk({tag, "_err"}, 64'(err_a), 64'(exp_err));
        chk({tag, "_rdata"}, 64'(rdata_a), 64'(exp));
        en_a = 1'b0;
    endtask

    initial begin
        // reset state
        tick(); tick();
        rd(0, LO, 0, 32'h0, "rst_cnt0");
        chk("rst_ovf", 64'(ovf_a), 64'h0);
        chk("rst_irq", 64'(irq_a), 64'h0);
        chk("idle_rdata", 64'(rdata_a), 64'h0);
        rst = 1'b0;
        repeat (10) tick();
        rd(0, LO, 0, 32'd10, "cycle_cnt10");
        rd(0, LO, 1, 32'd0, "idx1_zero");
        rd(0, CT, 0, 32'd0, "ctrl_zero");
        chk("ovf_idle", 64'(ovf_a), 64'h0);
        chk("irq_idle", 64'(irq_a), 64'h0);

        // event masking: several matching events count once per cycle
        wr(3'b001, EV, 2, 32'h4000_0005);
        events = 16'h0005; repeat (3) tick();
        events = 16'h0002; repeat (2) tick();
        events = '0;
        rd(0, LO, 2, 32'd3, "ev_count3");
        rd(0, EV, 2, 32'h4000_0005, "ev_reg2");

        // counter 0 mask is read-only; irq_en/ovf writable
        wr(3'b001, EV, 0, 32'hFFFF_FFFF);
        rd(0, EV, 0, 32'hC000_0000, "ev0_mask_ro");
        chk("irq_ev0", 64'(irq_a), 64'h1);
        wr(3'b001, EV, 0, 32'h0);
        chk("irq_ev0_clr", 64'(irq_a), 64'h0);

        // 8-bit wrap (B) and saturate (C) from 0xFE
        wr(3'b110, LO, 1, 32'hFE);
        wr(3'b110, EV, 1, 32'h4000_0001);
        events = 16'h0001;
        tick();
        rd(1, LO, 1, 32'hFF, "wrap_ff");
        chk("wrap_ovf_pre", 64'(ovf_b[1]), 64'h0);
        chk("wrap_irq_pre", 64'(irq_b), 64'h0);
        tick();
        rd(1, LO, 1, 32'h00, "wrap_00");
        rd(2, LO, 1, 32'hFF, "sat_ff");
        chk("wrap_ovf", 64'(ovf_b[1]), 64'h1);
        chk("wrap_irq", 64'(irq_b), 64'h1);
        chk("sat_ovf", 64'(ovf_c[1]), 64'h1);
        chk("sat_irq", 64'(irq_c), 64'h1);
        tick();
        events = '0;
        rd(1, LO, 1, 32'h01, "wrap_01");
        rd(2, LO, 1, 32'hFF, "sat_hold");
        rd(1, HI, 1, 32'h0, "w8_hi_zero");
        wr(3'b010, EV, 1, 32'h4000_0001);
        chk("ovf_clr", 64'(ovf_b[1]), 64'h0);
        chk("irq_clr", 64'(irq_b), 64'h0);
        rd(1, EV, 1, 32'h4000_0001, "ev_after_clr");
        rd(2, EV, 1, 32'hC000_0001, "sat_ev_ovf");
        events = 16'h0001;
        wr(3'b100, LO, 1, 32'h10);
        events = '0;
        rd(2, LO, 1, 32'h10, "write_wins");

        // 64-bit carry crosses halves on increment only
        wr(3'b001, LO, 0, 32'hFFFF_FFFF);
        wr(3'b001, HI, 0, 32'h0);
        tick(); tick();
        rd(0, LO, 0, 32'h1, "carry_lo");
        rd(0, HI, 0, 32'h1, "carry_hi");
        wr(3'b001, CT, 0, 32'h1);
        repeat (3) tick();
        rd(0, LO, 0, 32'h2, "inhibit_lo");
        rd(0, HI, 0, 32'h1, "inhibit_hi");
        rd(0, CT, 0, 32'h1, "ctrl_read");

        // nonexistent counters
        rd_err(LO, 9, 1'b1, 32'h0, "idx9");
        rd_err(EV, 8, 1'b1, 32'h0, "idx8");
        rd_err(LO, 7, 1'b0, 32'h0, "idx7");
        rd_err(CT, 9, 1'b0, 32'h1, "ctrl_idx9");
        wr(3'b001, LO, 9, 32'h1234);
        wr(3'b001, EV, 9, 32'hFFFF);
        rd(0, LO, 1, 32'h0, "err_no_alias_cnt");
        rd(0, EV, 1, 32'h0, "err_no_alias_ev");
        rd(0, LO, 0, 32'h2, "err_cnt0_kept");

        // reset mid-count
        events = 16'h0001;
        tick(); tick();
        rst = 1'b1;
        #1;
        rd(2, LO, 1, 32'h0, "midrst_c1");
        rd(2, EV, 1, 32'h0, "midrst_ev");
        rd(0, LO, 0, 32'h0, "midrst_a0");
        rd(0, CT, 0, 32'h0, "midrst_ctrl");
        chk("midrst_ovf_b", 64'(ovf_b), 64'h0);
        chk("midrst_ovf_c", 64'(ovf_c), 64'h0);
        chk("midrst_irq_c", 64'(irq_c), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
